adc733_rx: RTL and testbench
============================

ADC733_RX -- requirements
Module: adc733_rx

Interface
REQ-001 Parameter NCH, default 6, number of ADC channels per frame cycle (1..8).
REQ-002 Parameter DEPTH, default 8, output FIFO depth in words (power of 2, >=2).
REQ-003 SCLK  input  1  serial clock; all logic on rising edge.
REQ-004 rst_l  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  receive enable; low = SDOFS ignored, shifter held in IDLE.
REQ-006 ch_rst  input  1  synchronous channel-counter clear.
REQ-007 SDOFS  input  1  ADC serial data-out frame sync, high for one SCLK with MSB.
REQ-008 SDO  input  1  ADC serial data out, MSB first.
REQ-009 m_data  output  16  sample word at FIFO head.
REQ-010 m_ch  output  3  channel tag of m_data.
REQ-011 m_valid  output  1  FIFO non-empty.
REQ-012 m_ready  input  1  consumer accepts head word when m_valid & m_ready.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 ovf_clr  input  1  synchronous clear of ovf.
REQ-015 frame_err  output  1  one-cycle pulse on premature SDOFS.

Function
REQ-016 Shifter SHALL have two states: IDLE, SHIFT; 4-bit bit counter.
REQ-017 IDLE -> SHIFT on edge with en=1 & SDOFS=1; SDO sampled same edge as bit15, counter=1.
REQ-018 In SHIFT, each edge SHALL shift SDO in MSB-first and increment counter.
REQ-019 Edge sampling bit0 (16th bit) SHALL complete the word: push {word, ch} into FIFO, return to IDLE, or stay in SHIFT with counter=1 if SDOFS=1 on the next edge (back-to-back frames, no gap required).
REQ-020 SDOFS=1 while in SHIFT with counter 1..15 SHALL discard partial word, pulse frame_err for one cycle, restart capture with current SDO as bit15; ch not advanced.
REQ-021 Channel counter SHALL tag each completed word, then increment; NCH-1 wraps to 0.
REQ-022 ch_rst=1 SHALL set channel counter to 0, abort any partial word, force IDLE; FIFO contents unaffected; ch_rst dominates SDOFS same edge.
REQ-023 en falling mid-word SHALL abort partial word and force IDLE; no push.
REQ-024 Latency: m_valid SHALL be high on the cycle after the bit0 edge when FIFO was empty; show-ahead (m_data/m_ch valid whenever m_valid=1).
REQ-025 Pop occurs on edge with m_valid & m_ready; m_ready while empty has no effect.
REQ-026 Simultaneous push and pop SHALL both succeed, including when full; occupancy unchanged.
REQ-027 Push while full without pop SHALL drop the new word, keep FIFO intact, set ovf.
REQ-028 ovf SHALL remain set until ovf_clr; overflow on same edge as ovf_clr leaves ovf=1.
REQ-029 Pointers SHALL be log2(DEPTH) bits wrapping naturally, plus count register 0..DEPTH.
REQ-030 m_data/m_ch SHALL hold stable while m_valid & !m_ready.

Reset
REQ-031 rst_l low SHALL asynchronously force: state IDLE, bit counter 0, channel counter 0, FIFO empty, m_valid=0, m_data=0, m_ch=0, ovf=0, frame_err=0.
REQ-032 Reset mid-word SHALL discard the partial word; first accepted frame after release is tagged ch 0.
REQ-033 Release SHALL take effect on the first SCLK edge with rst_l high; SDOFS on that edge SHALL be accepted.

Verification
REQ-034 Single frame 0xA5C3, m_ready=1 -> m_valid high one cycle after bit0 edge, m_data=0xA5C3, m_ch=0.
REQ-035 7 back-to-back frames, NCH=6 -> tags 0,1,2,3,4,5,0; no gaps, no frame_err.
REQ-036 m_ready=0, 9 frames, DEPTH=8 -> 8 words stored, ovf=1, 9th dropped; drain yields first 8 in order.
REQ-037 SDOFS re-asserted after 7 bits, then full frame 0x1234 -> frame_err one-cycle pulse, single word 0x1234 tag 0.
REQ-038 Full FIFO, push and pop same edge -> count stays 8, ovf stays 0, new word at tail.
REQ-039 rst_l low after 10 bits of a frame, then one frame 0x00FF -> only 0x00FF, ch 0, all flags 0.

Source files
------------

// File: rtl/adc733_rx.sv
// adc733_rx -- serial receiver for an ADC733-style frame-synced data port.
//
// SDOFS marks the MSB of each 16-bit sample on SDO. The shifter assembles
// words MSB first, tags each completed word with a round-robin channel number
// (0..NCH-1) and pushes {ch, word} into a show-ahead FIFO drained through a
// valid/ready handshake. An overflow drops the incoming word and sets a
// sticky flag; a frame sync arriving mid-word produces a one-cycle error
// pulse and restarts capture on the new frame.
//
// Ports
//   SCLK       in   serial clock, all logic on the rising edge
//   rst_l      in   asynchronous active-low reset
//   en         in   receive enable; low ignores SDOFS and holds the shifter idle
//   ch_rst     in   synchronous channel-counter clear, also aborts a partial word
//   SDOFS      in   frame sync, high for one SCLK with the MSB
//   SDO        in   serial data, MSB first
//   m_data     out  [15:0] sample word at the FIFO head (0 when empty)
//   m_ch       out  [2:0]  channel tag of m_data (0 when empty)
//   m_valid    out  FIFO non-empty
//   m_ready    in   consumer accepts the head word when m_valid & m_ready
//   ovf        out  sticky overflow flag
//   ovf_clr    in   synchronous clear of ovf
//   frame_err  out  one-cycle pulse on a premature SDOFS
module adc733_rx #(
  parameter int NCH   = 6,
  parameter int DEPTH = 8
) (
  input  logic        SCLK,
  input  logic        rst_l,
  input  logic        en,
  input  logic        ch_rst,
  input  logic        SDOFS,
  input  logic        SDO,
  output logic [15:0] m_data,
  output logic [2:0]  m_ch,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic        frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [14:0]   sreg_q, sreg_d;
  logic [2:0]    ch_q;
  logic          push;
  logic          err_d;
  logic [15:0]   word;

  logic [18:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, wr_en;

  // State register plus the shifter datapath it steers
  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      frame_err <= err_d;
    end
  end

  always_ff @(posedge SCLK) begin
    sreg_q <= sreg_d;
  end

  // Next-state logic: ch_rst and a dropped enable both force IDLE first
  always_comb begin
    state_d = state_q;
    if (ch_rst || !en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (SDOFS) state_d = SHIFT;
        SHIFT:   if (!SDOFS && bcnt_q == 4'd15) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath control. The counter holds the number of bits already
  // captured, so the edge that sees bcnt_q == 15 is the one sampling bit0.
  // Any SDOFS while shifting is premature and restarts capture on this bit.
  always_comb begin
    bcnt_d = bcnt_q;
    sreg_d = sreg_q;
    push   = 1'b0;
    err_d  = 1'b0;
    if (ch_rst || !en) begin
      bcnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (SDOFS) begin
            bcnt_d = 4'd1;
            sreg_d = {14'd0, SDO};
          end
        end
        SHIFT: begin
          if (SDOFS) begin
            err_d  = 1'b1;
            bcnt_d = 4'd1;
            sreg_d = {14'd0, SDO};
          end else begin
            sreg_d = {sreg_q[13:0], SDO};
            bcnt_d = bcnt_q + 4'd1;
            push   = (bcnt_q == 4'd15);
          end
        end
        default: bcnt_d = '0;
      endcase
    end
  end

  assign word = {sreg_q, SDO};

  // Channel counter advances on every completed word, even one the FIFO drops
  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      ch_q <= '0;
    end else if (ch_rst) begin
      ch_q <= '0;
    end else if (push) begin
      ch_q <= (ch_q == 3'(NCH - 1)) ? 3'd0 : ch_q + 3'd1;
    end
  end

  // FIFO: a pop on the same edge frees the slot, so a push into a full FIFO
  // still succeeds when the head is being consumed.
  assign full    = (count == CW'(DEPTH));
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign wr_en   = push && (!full || pop);

  always_ff @(posedge SCLK) begin
    if (wr_en) mem[wr_ptr] <= {ch_q, word};
  end

  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new overflow wins over a clear on the same edge
      ovf <= (push && full && !pop) || (ovf && !ovf_clr);
    end
  end

  // Show-ahead head; forced to zero while empty so reset reads back as 0
  assign m_data = m_valid ? mem[rd_ptr][15:0]  : 16'd0;
  assign m_ch   = m_valid ? mem[rd_ptr][18:16] : 3'd0;

endmodule

// File: tb/tb_adc733_rx.sv
module tb_adc733_rx;

  logic        SCLK = 1'b0;
  logic        rst_l = 1'b0;
  logic        en = 1'b1;
  logic        ch_rst = 1'b0;
  logic        SDOFS = 1'b0;
  logic        SDO = 1'b0;
  logic [15:0] m_data;
  logic [2:0]  m_ch;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic        frame_err;

  int n_vec  = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int ch_exp = 0;
  logic [18:0] exp_q[$];

  adc733_rx #(.NCH(6), .DEPTH(8)) dut (
    .SCLK(SCLK), .rst_l(rst_l), .en(en), .ch_rst(ch_rst),
    .SDOFS(SDOFS), .SDO(SDO), .m_data(m_data), .m_ch(m_ch),
    .m_valid(m_valid), .m_ready(m_ready), .ovf(ovf), .ovf_clr(ovf_clr),
    .frame_err(frame_err)
  );

  always #5 SCLK = ~SCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  // First n bits of w, MSB first, frame sync on the first bit
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      SDOFS = (k == 0);
      SDO   = w[15-k];
      tick();
    end
    SDOFS = 1'b0;
    SDO   = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] w, input bit store, input bit rdy_last);
    if (store) exp_q.push_back({3'(ch_exp), w});
    for (int k = 0; k < 16; k++) begin
      SDOFS = (k == 0);
      SDO   = w[15-k];
      if (k == 15 && rdy_last) m_ready = 1'b1;
      tick();
    end
    if (rdy_last) m_ready = 1'b0;
    SDOFS = 1'b0;
    SDO   = 1'b0;
    ch_exp = (ch_exp == 5) ? 0 : ch_exp + 1;
  endtask

  task automatic do_ch_rst();
    ch_rst = 1'b1;
    tick();
    ch_rst = 1'b0;
    ch_exp = 0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 64) begin
      tick();
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    tick();
    check("empty_after_drain", m_valid, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a word
  initial begin
    logic        prev_hold;
    logic [18:0] prev_word;
    logic [18:0] e;
    prev_hold = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge SCLK);
      if (frame_err === 1'b1) err_cnt++;
      if (m_valid === 1'b1 && prev_hold) check("hold", {m_ch, m_data}, prev_word);
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_word: got %h, expected none", {m_ch, m_data});
        end else begin
          e = exp_q.pop_front();
          check("pop", {m_ch, m_data}, e);
        end
      end
      prev_hold = (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_word = {m_ch, m_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    // Reset state
    tick(); tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_ch", m_ch, 0);
    check("rst_ovf", ovf, 0);
    check("rst_frame_err", frame_err, 0);
    rst_l = 1'b1;

    // Single frame 0xA5C3; SDOFS on the first edge after release
    exp_q.push_back({3'd0, 16'hA5C3});
    send_bits(16'hA5C3, 15);
    check("lat_before_bit0", m_valid, 0);
    SDO = 1'b1;
    tick();
    SDO = 1'b0;
    ch_exp = 1;
    check("lat_valid", m_valid, 1);
    check("lat_data", m_data, 16'hA5C3);
    check("lat_ch", m_ch, 0);
    wait_drain();

    // Seven back-to-back frames: tags 0..5,0
    do_ch_rst();
    e0 = err_cnt;
    for (int i = 0; i < 7; i++) send_frame(16'h1000 + 16'(i) * 16'h0111, 1'b1, 1'b0);
    wait_drain();
    check("b2b_frame_err", err_cnt - e0, 0);

    // Overflow: 9 frames with m_ready low, first 8 kept
    do_ch_rst();
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_frame(16'h2000 + 16'(i), (i < 8), 1'b0);
    check("ovf_set", ovf, 1);
    check("ovf_head", {m_ch, m_data}, {3'd0, 16'h2000});
    m_ready = 1'b1;
    wait_drain();
    check("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Full FIFO with push and pop on the same edge
    do_ch_rst();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(16'h3000 + 16'(i), 1'b1, 1'b0);
    send_frame(16'h3ABC, 1'b1, 1'b1);
    check("full_pp_ovf", ovf, 0);
    check("full_pp_head", {m_ch, m_data}, {3'd1, 16'h3001});
    m_ready = 1'b1;
    wait_drain();

    // Premature SDOFS after 7 bits, then a full frame
    do_ch_rst();
    e0 = err_cnt;
    send_bits(16'hFFFF, 7);
    send_frame(16'h1234, 1'b1, 1'b0);
    wait_drain();
    check("ferr_pulse_cycles", err_cnt - e0, 1);

    // Reset after 10 bits, then one frame
    e0 = err_cnt;
    send_bits(16'hAAAA, 10);
    rst_l = 1'b0;
    ch_exp = 0;
    tick(); tick();
    check("midrst_valid", m_valid, 0);
    check("midrst_ovf", ovf, 0);
    rst_l = 1'b1;
    send_frame(16'h00FF, 1'b1, 1'b0);
    wait_drain();
    check("postrst_ovf", ovf, 0);
    check("postrst_ferr", err_cnt - e0, 0);

    // Enable dropped mid-word aborts it; SDOFS ignored while disabled
    e0 = err_cnt;
    send_bits(16'h5555, 5);
    en = 1'b0;
    SDOFS = 1'b1;
    tick();
    en = 1'b1;
    SDOFS = 1'b0;
    send_frame(16'hBEEF, 1'b1, 1'b0);
    wait_drain();
    check("en_abort_ferr", err_cnt - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
